// File: rtl/mem_arbiter.sv
// Two-master memory arbiter: CPU (m0) and loader/DMA (m1) share one
// registered memory port. Each access takes ISSUE (grant + strobe) then
// RESP (done + read data), so back-to-back traffic runs at one access
// per two cycles.
// Build option: define MEM_ARB_RR_EN for round-robin arbitration of
// simultaneous requests; otherwise m0 has fixed priority over m1.
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              m0_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [31:0]       m0_wdata,
  input  logic [3:0]        m0_wmask,
  output logic              m0_gnt,
  output logic              m0_done,
  output logic [31:0]       m0_rdata,
  input  logic              m1_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [31:0]       m1_wdata,
  input  logic [3:0]        m1_wmask,
  output logic              m1_gnt,
  output logic              m1_done,
  output logic [31:0]       m1_rdata,
  output logic              mem_strb,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t            state, state_nxt;
  logic              owner, owner_nxt;   // 0 = m0, 1 = m1
  logic              last, last_nxt;     // requester granted most recently
  logic              win;                // arbitration winner this cycle
  logic              load;               // latch winner onto memory port
  logic              rd;                 // current access is a read
  logic [ADDR_W-1:0] sel_addr;
  logic [31:0]       sel_wdata;
  logic [3:0]        sel_wmask;
  logic [31:0]       rdata0_q, rdata1_q;

  // Pick a winner among the live requests and mux its access fields.
  always_comb begin
`ifdef MEM_ARB_RR_EN
    if (m0_req && m1_req) win = ~last;
    else                  win = m1_req & ~m0_req;
`else
    win = ~m0_req;
`endif
    sel_addr  = win ? m1_addr  : m0_addr;
    sel_wdata = win ? m1_wdata : m0_wdata;
    sel_wmask = win ? m1_wmask : m0_wmask;
  end

  // Next-state logic: arbitrate in IDLE and RESP, ISSUE always moves to RESP.
  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    last_nxt  = last;
    load      = 1'b0;
    case (state)
      IDLE, RESP: begin
        if (m0_req || m1_req) begin
          state_nxt = ISSUE;
          owner_nxt = win;
          last_nxt  = win;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      ISSUE:   state_nxt = RESP;
      default: state_nxt = IDLE;
    endcase
  end

  // State, owner and last-grant registers; last grant resets to m1.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state <= IDLE;
      owner <= 1'b0;
      last  <= 1'b1;
    end else begin
      state <= state_nxt;
      owner <= owner_nxt;
      last  <= last_nxt;
    end
  end

  // Registered memory port: loaded for the ISSUE cycle, strobes cleared otherwise.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_strb  <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_wmask <= '0;
      rd        <= 1'b0;
    end else if (load) begin
      mem_strb  <= (sel_wmask == 4'b0000);
      mem_addr  <= sel_addr;
      mem_wdata <= sel_wdata;
      mem_wmask <= sel_wmask;
      rd        <= (sel_wmask == 4'b0000);
    end else begin
      mem_strb  <= 1'b0;
      mem_wmask <= '0;
    end
  end

  // Keep each requester's last read data after its done pulse.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else if (state == RESP && rd) begin
      if (owner) rdata1_q <= mem_rdata;
      else       rdata0_q <= mem_rdata;
    end
  end

  // Grant/done decode; read data passes straight through during the done cycle.
  always_comb begin
    m0_gnt   = (state == ISSUE) && !owner;
    m1_gnt   = (state == ISSUE) &&  owner;
    m0_done  = (state == RESP)  && !owner;
    m1_done  = (state == RESP)  &&  owner;
    m0_rdata = (m0_done && rd) ? mem_rdata : rdata0_q;
    m1_rdata = (m1_done && rd) ? mem_rdata : rdata1_q;
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: a transaction-timeline model checked
// every cycle, plus literal expectations for the directed scenarios.
module tb_mem_arbiter;

  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rstn = 1'b1;
  logic          m0_req = 1'b0, m1_req = 1'b0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [31:0]   m0_wdata = '0, m1_wdata = '0;
  logic [3:0]    m0_wmask = '0, m1_wmask = '0;
  logic          m0_gnt, m1_gnt, m0_done, m1_done;
  logic [31:0]   m0_rdata, m1_rdata;
  logic          mem_strb;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wmask;
  logic [31:0]   mem_rdata = '0;

  int n_cmp = 0;
  int n_bad = 0;

  mem_arbiter #(.ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn),
    .m0_req(m0_req), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_gnt(m0_gnt), .m0_done(m0_done), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_gnt(m1_gnt), .m1_done(m1_done), .m1_rdata(m1_rdata),
    .mem_strb(mem_strb), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wmask(mem_wmask), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %h want %h", name, $time, act, exp);
    end
  endtask

  // ---------------- timeline model ----------------
  // Each accepted request occupies the next cycle (grant) and the one after
  // (done). A request is only considered at an edge that does not end a
  // grant cycle.
  bit          busy_next;          // cycle just started is a done cycle
  bit          own;                // requester of the access in flight
  bit          own_rd;             // access in flight is a read
  bit          prev_win;           // requester granted most recently
  bit [1:0]    e_gnt, e_done;
  bit          e_strb;
  bit [3:0]    e_wmask;
  bit [31:0]   e_addr, e_wdata;
  bit [31:0]   held [2];

  function automatic bit pick(input bit r0, input bit r1, input bit last_w);
`ifdef MEM_ARB_RR_EN
    if (r0 && r1) return !last_w;
`else
    if (r0) return 1'b0;
`endif
    return r1 ? 1'b1 : 1'b0;
  endfunction

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_next = 0; own = 0; own_rd = 0; prev_win = 1;
      e_gnt = 0; e_done = 0; e_strb = 0; e_wmask = 0; e_addr = 0; e_wdata = 0;
      held[0] = 0; held[1] = 0;
    end else begin
      if (e_done[own] && own_rd) held[own] = mem_rdata;
      e_gnt = 0; e_done = 0; e_strb = 0; e_wmask = 0;
      if (busy_next) begin
        e_done[own] = 1;
        busy_next = 0;
      end else if (m0_req || m1_req) begin
        own      = pick(m0_req, m1_req, prev_win);
        prev_win = own;
        busy_next = 1;
        e_gnt[own] = 1;
        e_wmask  = own ? m1_wmask : m0_wmask;
        own_rd   = (e_wmask == 0);
        e_strb   = own_rd;
        e_addr   = own ? m1_addr : m0_addr;
        e_wdata  = own ? m1_wdata : m0_wdata;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    chk("m0_gnt", {31'b0, m0_gnt}, {31'b0, e_gnt[0]});
    chk("m1_gnt", {31'b0, m1_gnt}, {31'b0, e_gnt[1]});
    chk("m0_done", {31'b0, m0_done}, {31'b0, e_done[0]});
    chk("m1_done", {31'b0, m1_done}, {31'b0, e_done[1]});
    chk("mem_strb", {31'b0, mem_strb}, {31'b0, e_strb});
    chk("mem_wmask", {28'b0, mem_wmask}, {28'b0, e_wmask});
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("m0_rdata", m0_rdata, (e_done[0] && own_rd) ? mem_rdata : held[0]);
    chk("m1_rdata", m1_rdata, (e_done[1] && own_rd) ? mem_rdata : held[1]);
    chk("one_grant", {31'b0, m0_gnt & m1_gnt}, 32'd0);
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rstn = 1'b0;
    #2;
    chk("rst_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    chk("rst_mem_strb", {31'b0, mem_strb}, 32'd0);
    chk("rst_m1_rdata", m1_rdata, 32'd0);
    @(posedge clk); @(posedge clk); #2;

    // m0 read of 0x100, released together with reset
    mem_rdata = 32'hDEADBEEF; m0_addr = 32'h100; m0_wmask = 4'b0000;
    rstn = 1'b1; m0_req = 1'b1;
    step();
    chk("t1_gnt", {31'b0, m0_gnt}, 32'd1);
    chk("t1_strb", {31'b0, mem_strb}, 32'd1);
    chk("t1_addr", mem_addr, 32'h100);
    m0_req = 1'b0;
    step();
    chk("t1_done", {31'b0, m0_done}, 32'd1);
    chk("t1_rdata", m0_rdata, 32'hDEADBEEF);
    step();

    // m1 read to give it non-zero rdata
    mem_rdata = 32'hCAFEF00D; m1_addr = 32'h8; m1_wmask = 4'b0000; m1_req = 1'b1;
    step();
    chk("t2_gnt", {31'b0, m1_gnt}, 32'd1);
    m1_req = 1'b0;
    step();
    chk("t2_rdata", m1_rdata, 32'hCAFEF00D);
    step();

    // m1 partial write: no strobe, rdata untouched
    mem_rdata = 32'h55AA55AA; m1_addr = 32'h4; m1_wdata = 32'h12345678;
    m1_wmask = 4'b0011; m1_req = 1'b1;
    step();
    chk("t3_wmask", {28'b0, mem_wmask}, 32'h3);
    chk("t3_strb", {31'b0, mem_strb}, 32'd0);
    chk("t3_wdata", mem_wdata, 32'h12345678);
    m1_req = 1'b0;
    step();
    chk("t3_done", {31'b0, m1_done}, 32'd1);
    chk("t3_rdata", m1_rdata, 32'hCAFEF00D);
    step();

    // both requesting for four accesses
    mem_rdata = 32'h0BADF00D; m0_addr = 32'h200; m0_wmask = 4'b0000;
    m1_addr = 32'h300; m1_wdata = 32'hA5A5A5A5; m1_wmask = 4'b1111;
    m0_req = 1'b1; m1_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step();
`ifdef MEM_ARB_RR_EN
      chk("t4_m1_gnt", {31'b0, m1_gnt}, (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("t4_m0_gnt", {31'b0, m0_gnt}, (k % 2 == 0) ? 32'd1 : 32'd0);
`else
      chk("t4_m1_gnt", {31'b0, m1_gnt}, 32'd0);
      chk("t4_m0_gnt", {31'b0, m0_gnt}, 32'd1);
`endif
      if (k == 3) begin m0_req = 1'b0; m1_req = 1'b0; end
      step();
    end
    step();

    // reset asserted during ISSUE
    m0_addr = 32'h400; m0_req = 1'b1;
    step();
    chk("t5_gnt", {31'b0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    #1 rstn = 1'b0;
    #1;
    chk("t5_rst_gnt", {31'b0, m0_gnt}, 32'd0);
    chk("t5_rst_addr", mem_addr, 32'd0);
    chk("t5_rst_strb", {31'b0, mem_strb}, 32'd0);
    chk("t5_rst_rdata", m0_rdata, 32'd0);
    step();
    chk("t5_no_done", {31'b0, m0_done}, 32'd0);
    mem_rdata = 32'h600DCAFE; m1_addr = 32'h20; m1_wmask = 4'b0000;
    rstn = 1'b1; m1_req = 1'b1;
    step();
    chk("t5_m1_gnt", {31'b0, m1_gnt}, 32'd1);
    m1_req = 1'b0;
    step();
    chk("t5_m1_done", {31'b0, m1_done}, 32'd1);
    chk("t5_m1_rdata", m1_rdata, 32'h600DCAFE);
    step();

    // m0 re-requests in its done cycle: no idle gap
    mem_rdata = 32'h13579BDF; m0_addr = 32'h500; m0_req = 1'b1;
    step();
    m0_req = 1'b0;
    step();
    chk("t6_done", {31'b0, m0_done}, 32'd1);
    m0_req = 1'b1; m0_addr = 32'h504; mem_rdata = 32'h2468ACE0;
    step();
    chk("t6_regnt", {31'b0, m0_gnt}, 32'd1);
    chk("t6_addr", mem_addr, 32'h504);
    m0_req = 1'b0;
    step();
    chk("t6_rdata", m0_rdata, 32'h2468ACE0);
    step();

    // m0 request raised during m1's ISSUE is not taken until RESP arbitrates
    m1_addr = 32'h600; m1_req = 1'b1;
    step();
    m1_req = 1'b0; m0_req = 1'b1; m0_addr = 32'h700;
    step();
    chk("t7_m1_done", {31'b0, m1_done}, 32'd1);
    chk("t7_no_m0_gnt", {31'b0, m0_gnt}, 32'd0);
    step();
    chk("t7_m0_gnt", {31'b0, m0_gnt}, 32'd1);
    m0_req = 1'b0;
    step();
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
